vgachargen_scan_timing: RTL and testbench

- Parametrised VGA text-mode scan controller for the next generation of the character generator.
- Derives the pixel tick from the fast system clock and generates the h/v counters and sync/active signals with programmable timing and polarity.
- Produces the text-buffer character address, the glyph pixel coordinates and a blink phase.
- Delays sync/active by a parameterised number of pixel ticks to match text-RAM plus font-ROM read latency.
- Sits between the clock/reset wrapper and the text buffer and font ROM.

---
 rtl/vgachargen_scan_timing.sv | 235 +++++++++++++++++++++++
 tb/tb_vgachargen_scan_timing.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vgachargen_scan_timing.sv
// VGA text-mode scan controller: pixel-tick divider, h/v raster counters,
// programmable sync/active decode, text-buffer addressing, glyph coordinates,
// blink phase, and a pixel-tick delay line that aligns sync/active with the
// text-RAM plus font-ROM read latency.
module vgachargen_scan_timing #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit H_POL        = 1'b0,
  parameter bit V_POL        = 1'b0,
  parameter int CLK_DIV      = 5,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 8,
  parameter int PIPE         = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pix_en_o,
  output logic [$clog2((H_ACTIVE/GLYPH_W)*(V_ACTIVE/GLYPH_H))-1:0] char_addr_o,
  output logic [$clog2(GLYPH_W)-1:0] glyph_x_o,
  output logic [$clog2(GLYPH_H)-1:0] glyph_y_o,
  output logic frame_start_o,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic blink_o,
  // glyph column delayed by PIPE pixel ticks, aligned with active_o for the serialiser
  output logic [$clog2(GLYPH_W)-1:0] glyph_x_dly_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE / GLYPH_W;
  localparam int ROWS    = V_ACTIVE / GLYPH_H;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(COLS * ROWS);
  localparam int GXW     = $clog2(GLYPH_W);
  localparam int GYW     = $clog2(GLYPH_H);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  // The glyph grid must tile the visible area exactly, otherwise the
  // shift-based character addressing would not match the screen layout.
  if ((H_ACTIVE % GLYPH_W) != 0 || (V_ACTIVE % GLYPH_H) != 0) begin : g_bad_glyph
    $error("vgachargen_scan_timing: active area is not a multiple of the glyph size");
  end

  logic [DW-1:0]  div_cnt_reg;
  logic           pix_en_reg;
  logic [HW-1:0]  h_cnt_reg;
  logic [VW-1:0]  v_cnt_reg;
  logic [FW-1:0]  frame_cnt_reg;
  logic           blink_reg;
  logic           h_wrap;
  logic           v_wrap;

  logic           act_next;
  logic           hs_next;
  logic           vs_next;
  logic           fs_next;
  logic [AW-1:0]  addr_next;
  logic [GXW-1:0] gx_next;
  logic [GYW-1:0] gy_next;

  logic           act_reg;
  logic           hs_reg;
  logic           vs_reg;
  logic           fs_reg;
  logic [AW-1:0]  addr_reg;
  logic [GXW-1:0] gx_reg;
  logic [GYW-1:0] gy_reg;

  logic           act_dly;
  logic           hs_dly;
  logic           vs_dly;
  logic [GXW-1:0] gx_dly;

  // Pixel-tick divider: one-clock strobe every CLK_DIV system clocks
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_reg <= '0;
      pix_en_reg  <= 1'b0;
    end else begin
      pix_en_reg  <= (div_cnt_reg == DIV_LAST);
      div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DW'(1);
    end
  end

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  // Raster position counters, advancing once per pixel tick
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pix_en_reg) begin
      h_cnt_reg <= h_wrap ? '0 : h_cnt_reg + HW'(1);
      if (h_wrap) begin
        v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + VW'(1);
      end
    end
  end

  // Decode of the current raster position into visibility, sync and addressing
  always_comb begin
    act_next  = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
    hs_next   = ((int'(h_cnt_reg) >= H_ACTIVE + H_FP) &&
                 (int'(h_cnt_reg) <  H_ACTIVE + H_FP + H_SYNC)) ? H_POL : ~H_POL;
    vs_next   = ((int'(v_cnt_reg) >= V_ACTIVE + V_FP) &&
                 (int'(v_cnt_reg) <  V_ACTIVE + V_FP + V_SYNC)) ? V_POL : ~V_POL;
    fs_next   = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    addr_next = '0;
    gx_next   = '0;
    gy_next   = '0;
    if (act_next) begin
      // glyph sizes are powers of two, so row/column come from shifts and the
      // row stride is a constant multiply
      addr_next = AW'(int'(v_cnt_reg >> GYW) * COLS + int'(h_cnt_reg >> GXW));
      gx_next   = h_cnt_reg[GXW-1:0];
      gy_next   = v_cnt_reg[GYW-1:0];
    end
  end

  // Register the decode on the pixel tick so outputs hold for a whole pixel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_reg  <= 1'b0;
      hs_reg   <= ~H_POL;
      vs_reg   <= ~V_POL;
      fs_reg   <= 1'b0;
      addr_reg <= '0;
      gx_reg   <= '0;
      gy_reg   <= '0;
    end else if (pix_en_reg) begin
      act_reg  <= act_next;
      hs_reg   <= hs_next;
      vs_reg   <= vs_next;
      fs_reg   <= fs_next;
      addr_reg <= addr_next;
      gx_reg   <= gx_next;
      gy_reg   <= gy_next;
    end
  end

  // Blink phase: toggles every BLINK_FRAMES complete frames
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (pix_en_reg && h_wrap && v_wrap) begin
      if (frame_cnt_reg == BLINK_LAST) begin
        frame_cnt_reg <= '0;
        blink_reg     <= ~blink_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + FW'(1);
      end
    end
  end

  // Delay line: sync/active/glyph column shifted by PIPE pixel ticks
  if (PIPE == 0) begin : g_nopipe
    assign act_dly = act_reg;
    assign hs_dly  = hs_reg;
    assign vs_dly  = vs_reg;
    assign gx_dly  = gx_reg;
  end else begin : g_pipe
    for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
      logic           act_sr_reg;
      logic           hs_sr_reg;
      logic           vs_sr_reg;
      logic [GXW-1:0] gx_sr_reg;
      logic           act_src;
      logic           hs_src;
      logic           vs_src;
      logic [GXW-1:0] gx_src;

      if (gi == 0) begin : g_head
        assign act_src = act_reg;
        assign hs_src  = hs_reg;
        assign vs_src  = vs_reg;
        assign gx_src  = gx_reg;
      end else begin : g_link
        assign act_src = g_stage[gi-1].act_sr_reg;
        assign hs_src  = g_stage[gi-1].hs_sr_reg;
        assign vs_src  = g_stage[gi-1].vs_sr_reg;
        assign gx_src  = g_stage[gi-1].gx_sr_reg;
      end

      // One stage of the pixel-tick shift register, cleared to deasserted levels
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          act_sr_reg <= 1'b0;
          hs_sr_reg  <= ~H_POL;
          vs_sr_reg  <= ~V_POL;
          gx_sr_reg  <= '0;
        end else if (pix_en_reg) begin
          act_sr_reg <= act_src;
          hs_sr_reg  <= hs_src;
          vs_sr_reg  <= vs_src;
          gx_sr_reg  <= gx_src;
        end
      end
    end

    assign act_dly = g_stage[PIPE-1].act_sr_reg;
    assign hs_dly  = g_stage[PIPE-1].hs_sr_reg;
    assign vs_dly  = g_stage[PIPE-1].vs_sr_reg;
    assign gx_dly  = g_stage[PIPE-1].gx_sr_reg;
  end

  assign pix_en_o      = pix_en_reg;
  assign char_addr_o   = addr_reg;
  assign glyph_x_o     = gx_reg;
  assign glyph_y_o     = gy_reg;
  assign frame_start_o = fs_reg;
  assign active_o      = act_dly;
  assign hsync_o       = hs_dly;
  assign vsync_o       = vs_dly;
  assign blink_o       = blink_reg;
  assign glyph_x_dly_o = gx_dly;

endmodule

// File: tb/tb_vgachargen_scan_timing.sv
// Scoreboard bench for vgachargen_scan_timing using a small raster so several
// full frames fit in the run. A reference process derives every expected pixel
// output from the tick index with plain arithmetic; a monitor compares them.
module tb_vgachargen_scan_timing;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 2;
  localparam int HPOL = 0, VPOL = 1;
  localparam int D = 3, GW = 8, GH = 4, PIPE = 2, BF = 2;
  localparam int HT = HA + HF + HS + HB;   // 48
  localparam int VT = VA + VF + VS + VB;   // 22
  localparam int FT = HT * VT;             // ticks per frame
  localparam int COLS = HA / GW;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       pix_en;
  logic [3:0] char_addr;
  logic [2:0] glyph_x;
  logic [1:0] glyph_y;
  logic       frame_start;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       blink;
  logic [2:0] glyph_x_dly;

  vgachargen_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'(HPOL)), .V_POL(1'(VPOL)), .CLK_DIV(D),
    .GLYPH_W(GW), .GLYPH_H(GH), .PIPE(PIPE), .BLINK_FRAMES(BF)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .pix_en_o(pix_en),
    .char_addr_o(char_addr),
    .glyph_x_o(glyph_x),
    .glyph_y_o(glyph_y),
    .frame_start_o(frame_start),
    .active_o(active),
    .hsync_o(hsync),
    .vsync_o(vsync),
    .blink_o(blink),
    .glyph_x_dly_o(glyph_x_dly)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int addr;
    int gx;
    int gy;
    int fs;
    int act;
    int hs;
    int vs;
    int gxd;
    int blink;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, req);
    end
  endtask

  // Expected outputs after the n-th pixel tick since reset release
  function automatic exp_t ref_tick(input int n);
    exp_t e;
    int h, v, m, hm, vm, dact;
    h = n % HT;
    v = (n / HT) % VT;
    e.n     = n;
    e.act   = (h < HA && v < VA) ? 1 : 0;
    e.addr  = e.act ? (v / GH) * COLS + h / GW : 0;
    e.gx    = e.act ? h % GW : 0;
    e.gy    = e.act ? v % GH : 0;
    e.fs    = (h == 0 && v == 0) ? 1 : 0;
    m = n - PIPE;
    if (m < 0) begin
      e.act = 0;
      e.hs  = 1 - HPOL;
      e.vs  = 1 - VPOL;
      e.gxd = 0;
    end else begin
      hm   = m % HT;
      vm   = (m / HT) % VT;
      dact = (hm < HA && vm < VA) ? 1 : 0;
      e.act = dact;
      e.hs  = (hm >= HA + HF && hm < HA + HF + HS) ? HPOL : 1 - HPOL;
      e.vs  = (vm >= VA + VF && vm < VA + VF + VS) ? VPOL : 1 - VPOL;
      e.gxd = dact ? hm % GW : 0;
    end
    e.blink = (((n + 1) / FT) / BF) % 2;
    return e;
  endfunction

  // Reference: counts clocks since release, checks the tick strobe and
  // queues the expected pixel outputs for each tick
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      if (rst_i) begin
        c = 0;
        sb_q.delete();
      end else begin
        c++;
        if (c > D && (c - 1) % D == 0) sb_q.push_back(ref_tick((c - 1) / D - 1));
      end
      @(negedge clk);
      if (rst_i) begin
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_char_addr", int'(char_addr), 0);
        chk("rst_glyph_x", int'(glyph_x), 0);
        chk("rst_glyph_y", int'(glyph_y), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_hsync", int'(hsync), 1 - HPOL);
        chk("rst_vsync", int'(vsync), 1 - VPOL);
        chk("rst_blink", int'(blink), 0);
        chk("rst_glyph_x_dly", int'(glyph_x_dly), 0);
      end else begin
        chk($sformatf("pix_en clk%0d", c), int'(pix_en), (c % D == 0) ? 1 : 0);
      end
    end
  end

  // Monitor: after each pixel tick, pop the expectation and compare
  initial begin
    bit prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev = 1'b0;
      end else begin
        if (prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: tick seen got 0 queued expected 1");
          end else begin
            e = sb_q.pop_front();
            ticks_seen++;
            chk($sformatf("char_addr t%0d", e.n), int'(char_addr), e.addr);
            chk($sformatf("glyph_x t%0d", e.n), int'(glyph_x), e.gx);
            chk($sformatf("glyph_y t%0d", e.n), int'(glyph_y), e.gy);
            chk($sformatf("frame_start t%0d", e.n), int'(frame_start), e.fs);
            chk($sformatf("active t%0d", e.n), int'(active), e.act);
            chk($sformatf("hsync t%0d", e.n), int'(hsync), e.hs);
            chk($sformatf("vsync t%0d", e.n), int'(vsync), e.vs);
            chk($sformatf("glyph_x_dly t%0d", e.n), int'(glyph_x_dly), e.gxd);
            chk($sformatf("blink t%0d", e.n), int'(blink), e.blink);
          end
        end
        prev = pix_en;
      end
    end
  end

  // Stimulus: random-length runs interrupted by asynchronous mid-frame resets
  initial begin
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(2 * FT * D, FT * D / 2)) @(posedge clk);
      #1 rst_i = 1'b1;
      repeat ($urandom_range(3, 1)) @(posedge clk);
      @(negedge clk);
      #2 rst_i = 1'b0;
    end
    repeat (6 * FT * D + $urandom_range(FT * D, 0)) @(posedge clk);
    @(negedge clk);
    #1;
    chk("ticks_compared_enough", (ticks_seen >= 6 * FT) ? 1 : 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
